// File: rtl/instr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_buffer
// Brief    : Fetch-to-decode instruction FIFO; compacts masked fetch groups
//            and presents up to INSTR_PER_FETCH oldest instructions per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module instr_buffer #(
    parameter int INSTR_PER_FETCH = 4,
    parameter int ILEN            = 32,
    parameter int DEPTH           = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              fe2ibuf_valid_i,
    output logic                              ibuf2fe_ready_o,
    input  logic [INSTR_PER_FETCH*ILEN-1:0]   fe_instrs_i,
    input  logic [INSTR_PER_FETCH*32-1:0]     fe_pcs_i,
    input  logic [INSTR_PER_FETCH-1:0]        fe_slot_valid_i,
    input  logic [INSTR_PER_FETCH*32-1:0]     fe_pred_npc_i,
    output logic                              ibuf2dec_valid_o,
    input  logic                              dec2ibuf_ready_i,
    output logic [INSTR_PER_FETCH*ILEN-1:0]   ibuf_instrs_o,
    output logic [INSTR_PER_FETCH*32-1:0]     ibuf_pcs_o,
    output logic [INSTR_PER_FETCH-1:0]        ibuf_slot_valid_o,
    output logic [INSTR_PER_FETCH*32-1:0]     ibuf_pred_npc_o,
    output logic [$clog2(DEPTH):0]            count_o
);

    localparam int c_FW    = INSTR_PER_FETCH;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [ILEN-1:0]    r_instr [DEPTH];
    logic [31:0]        r_pc    [DEPTH];
    logic [31:0]        r_npc   [DEPTH];

    logic [c_CNT_W-1:0] w_free;
    logic [c_CNT_W-1:0] w_n_push;
    logic [c_CNT_W-1:0] w_n_pres;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_push_fire;
    logic               w_pop_fire;
    logic [c_PTR_W-1:0] w_wr_idx [c_FW];

    function automatic logic [c_CNT_W-1:0] f_popcnt(input logic [c_FW-1:0] v);
        logic [c_CNT_W-1:0] s;
        s = '0;
        for (int k = 0; k < c_FW; k++) begin
            s = s + {{(c_CNT_W-1){1'b0}}, v[k]};
        end
        return s;
    endfunction

    // Ready depends on registered occupancy only, so a same-cycle pop never raises it.
    assign w_free           = c_CNT_W'(DEPTH) - r_count;
    assign ibuf2fe_ready_o  = (w_free >= c_CNT_W'(c_FW));
    assign ibuf2dec_valid_o = (r_count != '0);
    assign count_o          = r_count;

    assign w_n_push    = f_popcnt(fe_slot_valid_i);
    assign w_n_pres    = (r_count < c_CNT_W'(c_FW)) ? r_count : c_CNT_W'(c_FW);
    assign w_push_fire = fe2ibuf_valid_i & ibuf2fe_ready_o & ~flush_i;
    assign w_pop_fire  = ibuf2dec_valid_o & dec2ibuf_ready_i & ~flush_i;

    assign w_count_nxt = r_count
                       + (w_push_fire ? w_n_push : '0)
                       - (w_pop_fire  ? w_n_pres : '0);

    // Each valid slot lands at tail plus the number of valid slots below it.
    for (genvar gi = 0; gi < c_FW; gi++) begin : g_wr_idx
        localparam logic [c_FW-1:0] c_LOW_MASK = c_FW'((1 << gi) - 1);
        logic [c_CNT_W-1:0] w_off;
        assign w_off         = f_popcnt(fe_slot_valid_i & c_LOW_MASK);
        assign w_wr_idx[gi]  = r_tail + w_off[c_PTR_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (w_push_fire) begin
            for (int i = 0; i < c_FW; i++) begin
                if (fe_slot_valid_i[i]) begin
                    r_instr[w_wr_idx[i]] <= fe_instrs_i[i*ILEN +: ILEN];
                    r_pc[w_wr_idx[i]]    <= fe_pcs_i[i*32 +: 32];
                    r_npc[w_wr_idx[i]]   <= fe_pred_npc_i[i*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_fire) begin
                r_tail <= r_tail + w_n_push[c_PTR_W-1:0];
            end
            if (w_pop_fire) begin
                r_head <= r_head + w_n_pres[c_PTR_W-1:0];
            end
            r_count <= w_count_nxt;
        end
    end

    for (genvar gs = 0; gs < c_FW; gs++) begin : g_present
        logic [c_PTR_W-1:0] w_rd_idx;
        logic               w_slot_vld;
        assign w_rd_idx   = r_head + c_PTR_W'(gs);
        assign w_slot_vld = (c_CNT_W'(gs) < w_n_pres);

        assign ibuf_slot_valid_o[gs]           = w_slot_vld;
        assign ibuf_instrs_o[gs*ILEN +: ILEN]  = w_slot_vld ? r_instr[w_rd_idx] : '0;
        assign ibuf_pcs_o[gs*32 +: 32]         = w_slot_vld ? r_pc[w_rd_idx]    : '0;
        assign ibuf_pred_npc_o[gs*32 +: 32]    = w_slot_vld ? r_npc[w_rd_idx]   : '0;
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    r_count <= c_CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_instr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_buffer
// Brief    : Self-checking bench for instr_buffer (FW=DW=4, DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_buffer;

    localparam int c_FW    = 4;
    localparam int c_DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         fe_valid = 1'b0;
    logic         fe_ready;
    logic [127:0] fe_instrs = '0;
    logic [127:0] fe_pcs = '0;
    logic [3:0]   fe_mask = '0;
    logic [127:0] fe_npc = '0;
    logic         dec_valid;
    logic         dec_ready = 1'b0;
    logic [127:0] o_instrs;
    logic [127:0] o_pcs;
    logic [3:0]   o_mask;
    logic [127:0] o_npc;
    logic [4:0]   o_count;

    int errors = 0;
    int checks = 0;

    instr_buffer #(
        .INSTR_PER_FETCH (c_FW),
        .ILEN            (32),
        .DEPTH           (c_DEPTH)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .flush_i           (flush),
        .fe2ibuf_valid_i   (fe_valid),
        .ibuf2fe_ready_o   (fe_ready),
        .fe_instrs_i       (fe_instrs),
        .fe_pcs_i          (fe_pcs),
        .fe_slot_valid_i   (fe_mask),
        .fe_pred_npc_i     (fe_npc),
        .ibuf2dec_valid_o  (dec_valid),
        .dec2ibuf_ready_i  (dec_ready),
        .ibuf_instrs_o     (o_instrs),
        .ibuf_pcs_o        (o_pcs),
        .ibuf_slot_valid_o (o_mask),
        .ibuf_pred_npc_o   (o_npc),
        .count_o           (o_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: an ordered list of buffered instructions.
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;
    ent_t q[$];
    bit   known = 1'b0;

    function automatic logic [31:0] f_ins(input logic [31:0] pc);
        return (pc << 8) | 32'h13;
    endfunction

    function automatic logic [31:0] f_npc(input logic [31:0] pc);
        return pc + 32'h10;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_check();
        int n;
        logic [127:0] e_ins, e_pc, e_npc;
        logic [3:0]   e_mask;
        n      = (q.size() < c_FW) ? q.size() : c_FW;
        e_ins  = '0;
        e_pc   = '0;
        e_npc  = '0;
        e_mask = '0;
        for (int i = 0; i < n; i++) begin
            e_ins[i*32 +: 32] = q[i].ins;
            e_pc[i*32 +: 32]  = q[i].pc;
            e_npc[i*32 +: 32] = q[i].npc;
            e_mask[i]         = 1'b1;
        end
        chk("model_count",  128'(o_count),   128'(q.size()));
        chk("model_valid",  128'(dec_valid), 128'(q.size() != 0));
        chk("model_ready",  128'(fe_ready),  128'((c_DEPTH - q.size()) >= c_FW));
        chk("model_mask",   128'(o_mask),    128'(e_mask));
        chk("model_instrs", o_instrs, e_ins);
        chk("model_pcs",    o_pcs,    e_pc);
        chk("model_npc",    o_npc,    e_npc);
    endtask

    task automatic model_update(input bit r, input bit f, input bit fv,
                                input bit [3:0] m, input bit dr, input logic [31:0] pcb);
        bit acc, pop;
        int n;
        if (!r || f) begin
            q.delete();
            known = known | !r;
            return;
        end
        acc = fv && ((c_DEPTH - q.size()) >= c_FW);
        pop = dr && (q.size() != 0);
        n   = (q.size() < c_FW) ? q.size() : c_FW;
        if (pop) begin
            for (int i = 0; i < n; i++) void'(q.pop_front());
        end
        if (acc) begin
            for (int i = 0; i < c_FW; i++) begin
                if (m[i]) q.push_back('{ins: f_ins(pcb + 4*i), pc: pcb + 4*i, npc: f_npc(pcb + 4*i)});
            end
        end
    endtask

    // One clock: drive inputs, check against the model at negedge, advance the model.
    task automatic step(input bit r, input bit f, input bit fv, input bit [3:0] m,
                        input bit dr, input logic [31:0] pcb);
        rst_n     = r;
        flush     = f;
        fe_valid  = fv;
        fe_mask   = m;
        dec_ready = dr;
        for (int i = 0; i < c_FW; i++) begin
            fe_pcs[i*32 +: 32]    = pcb + 4*i;
            fe_instrs[i*32 +: 32] = f_ins(pcb + 4*i);
            fe_npc[i*32 +: 32]    = f_npc(pcb + 4*i);
        end
        @(negedge clk);
        if (known) model_check();
        @(posedge clk);
        model_update(r, f, fv, m, dr, pcb);
        #1;
    endtask

    typedef struct {
        bit          rst_n;
        bit          flush;
        bit          fv;
        bit [3:0]    mask;
        bit          dr;
        int unsigned exp_cnt;
        bit [3:0]    exp_mask;
        bit          exp_valid;
        bit          exp_ready;
    } vec_t;
    vec_t vq[$];

    task automatic add(input bit r, input bit f, input bit fv, input bit [3:0] m, input bit dr,
                       input int unsigned ec, input bit [3:0] em, input bit ev, input bit er);
        vq.push_back('{r, f, fv, m, dr, ec, em, ev, er});
    endtask

    logic [31:0] exp_pc;

    initial begin
        //   rst flu fv  mask     dr  cnt mask     vld rdy
        add(0, 0, 0, 4'b0000, 0,  0, 4'b0000, 0, 1);
        add(0, 0, 0, 4'b0000, 0,  0, 4'b0000, 0, 1);
        add(1, 0, 1, 4'b1010, 0,  2, 4'b0011, 1, 1);
        add(1, 0, 1, 4'b1111, 0,  6, 4'b1111, 1, 1);
        add(1, 0, 1, 4'b1111, 0, 10, 4'b1111, 1, 1);
        add(1, 0, 1, 4'b0111, 0, 13, 4'b1111, 1, 0);
        add(1, 0, 1, 4'b1111, 0, 13, 4'b1111, 1, 0);
        add(1, 0, 0, 4'b0000, 1,  9, 4'b1111, 1, 1);
        add(1, 0, 1, 4'b0000, 0,  9, 4'b1111, 1, 1);
        add(1, 1, 1, 4'b1111, 1,  0, 4'b0000, 0, 1);
        add(1, 0, 1, 4'b1111, 0,  4, 4'b1111, 1, 1);
        add(1, 0, 1, 4'b1111, 0,  8, 4'b1111, 1, 1);
        add(1, 0, 1, 4'b1111, 0, 12, 4'b1111, 1, 1);
        add(1, 0, 1, 4'b1111, 0, 16, 4'b1111, 1, 0);
        add(1, 0, 0, 4'b0000, 1, 12, 4'b1111, 1, 1);
        add(1, 0, 0, 4'b0000, 1,  8, 4'b1111, 1, 1);
        add(1, 0, 1, 4'b0001, 1,  5, 4'b1111, 1, 1);
        add(1, 0, 0, 4'b0000, 1,  1, 4'b0001, 1, 1);
        add(1, 0, 0, 4'b0000, 1,  0, 4'b0000, 0, 1);
        add(1, 0, 1, 4'b0111, 0,  3, 4'b0111, 1, 1);
        add(1, 0, 0, 4'b0000, 1,  0, 4'b0000, 0, 1);

        foreach (vq[k]) begin
            step(vq[k].rst_n, vq[k].flush, vq[k].fv, vq[k].mask, vq[k].dr, 32'h1000 + 32'(k) * 32'h10);
            chk($sformatf("tbl%0d_count", k), 128'(o_count),   128'(vq[k].exp_cnt));
            chk($sformatf("tbl%0d_mask",  k), 128'(o_mask),    128'(vq[k].exp_mask));
            chk($sformatf("tbl%0d_valid", k), 128'(dec_valid), 128'(vq[k].exp_valid));
            chk($sformatf("tbl%0d_ready", k), 128'(fe_ready),  128'(vq[k].exp_ready));
        end

        // Compaction of a sparse mask.
        step(0, 0, 0, 4'b0000, 0, 32'h0);
        step(0, 0, 0, 4'b0000, 0, 32'h0);
        step(1, 0, 1, 4'b1010, 0, 32'h100);
        chk("compact_pc0",  128'(o_pcs[31:0]),  128'(32'h104));
        chk("compact_pc1",  128'(o_pcs[63:32]), 128'(32'h10C));
        chk("compact_mask", 128'(o_mask),       128'(4'b0011));
        chk("compact_cnt",  128'(o_count),      128'(2));
        step(1, 0, 0, 4'b0000, 1, 32'h0);

        // Flush dominates a simultaneous push and pop.
        step(1, 0, 1, 4'b1111, 0, 32'h200);
        step(1, 0, 1, 4'b1111, 0, 32'h210);
        chk("pre_flush_cnt", 128'(o_count), 128'(8));
        step(1, 1, 1, 4'b1111, 1, 32'h220);
        chk("flush_cnt",   128'(o_count),   128'(0));
        chk("flush_valid", 128'(dec_valid), 128'(0));
        step(1, 0, 1, 4'b0100, 0, 32'h2000);
        chk("post_flush_pc0",  128'(o_pcs[31:0]), 128'(32'h2008));
        chk("post_flush_mask", 128'(o_mask),      128'(4'b0001));
        step(1, 0, 0, 4'b0000, 1, 32'h0);

        // Streaming with decoder always ready; pointers wrap several times.
        exp_pc = 32'h3000;
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 1, 4'b1111, 1, 32'h3000 + 32'(k) * 32'h10);
            chk($sformatf("stream%0d_cnt", k), 128'(o_count), 128'(4));
            for (int i = 0; i < c_FW; i++) begin
                chk($sformatf("stream%0d_pc%0d", k, i), 128'(o_pcs[i*32 +: 32]), 128'(exp_pc));
                exp_pc = exp_pc + 32'h4;
            end
        end
        step(1, 0, 0, 4'b0000, 1, 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(63) != 0), ($urandom_range(31) == 0), ($urandom_range(3) != 0),
                 4'($urandom_range(15)), 1'($urandom_range(1)), $urandom & 32'hFFFF_FFF0);
        end
        step(1, 0, 0, 4'b0000, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_buffer.md
# instr_buffer

Instruction buffer between fetch and decode. Accepts fetch groups of up to `INSTR_PER_FETCH` instructions with a per-slot valid mask, compacts the valid slots into a per-instruction circular FIFO, and presents up to `INSTR_PER_FETCH` oldest instructions per cycle to `decoder`. Absorbs fetch/decode rate mismatch. Clears on a backend flush.

## Interface
- `Cfg`, `global_config_pkg::Cfg`: configuration. Uses `INSTR_PER_FETCH` as both fetch width FW and decode width DW, and `ILEN`, default 32.
- `DEPTH`, 16: FIFO entries, counted in instructions. Must be a power of two and at least 2*FW.

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `rst_ni` in 1: reset, synchronous and active-low.
- `flush_i` in 1: discard all buffered instructions.
- `fe2ibuf_valid_i` in 1: fetch group valid.
- `ibuf2fe_ready_o` out 1: buffer can accept a full group.
- `fe_instrs_i` in FW×ILEN: fetch group instructions.
- `fe_pcs_i` in FW×32: PC of each slot.
- `fe_slot_valid_i` in FW: per-slot valid mask. Any pattern is legal.
- `fe_pred_npc_i` in FW×32: predicted next PC of each slot.
- `ibuf2dec_valid_o` out 1: at least one instruction is presented.
- `dec2ibuf_ready_i` in 1: decoder accepts the presented group.
- `ibuf_instrs_o` out DW×ILEN: presented instructions.
- `ibuf_pcs_o` out DW×32: presented PCs.
- `ibuf_slot_valid_o` out DW: presented slot mask. Always packed low-first.
- `ibuf_pred_npc_o` out DW×32: presented predicted next PCs.
- `count_o` out $clog2(DEPTH)+1: current occupancy.

## Operation
- **State.** Storage arrays for instr, pc and pred_npc. Head pointer and tail pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy register `count`.
- **Push.**
  - push_fire = `fe2ibuf_valid_i` & `ibuf2fe_ready_o` & !`flush_i`.
  - The k-th set bit of `fe_slot_valid_i`, in ascending slot order, is written to entry (tail+k) mod DEPTH.
  - n_push = popcount(mask). Tail advances by n_push.
  - A mask of 0 with valid asserted is a no-op.
- **Ready.** `ibuf2fe_ready_o` = (DEPTH − count) ≥ FW.
  - Computed from registered count only.
  - A pop in the same cycle does not raise it.
- **Present.**
  - n_pres = min(count, DW).
  - Slot i (i < n_pres) shows entry (head+i) mod DEPTH.
  - `ibuf_slot_valid_o`[i] = (i < n_pres).
  - Data outputs of invalid slots are driven to 0.
  - `ibuf2dec_valid_o` = (count ≠ 0).
- **Pop.**
  - pop_fire = `ibuf2dec_valid_o` & `dec2ibuf_ready_i` & !`flush_i`.
  - All presented slots are consumed; head advances by n_pres.
- **Occupancy.**
  - count' = count + (push_fire ? n_push : 0) − (pop_fire ? n_pres : 0).
  - Simultaneous push and pop are supported.
  - Entries written this cycle are not presented until the next cycle.
- **Flush.**
  - `flush_i` sets head = tail = 0 and count = 0 on the next edge.
  - Flush dominates push and pop in the same cycle: the incoming group is dropped and nothing is popped.
- **Overflow/underflow.** Cannot occur by construction. An assertion checks count ≤ DEPTH.

## Timing
- **Reset** (`rst_ni`=0 at a rising edge): head, tail and count are 0. The arrays are not reset.
- **Outputs after reset:**
  - `ibuf2dec_valid_o`=0, `ibuf_slot_valid_o`=0, all data outputs 0.
  - `ibuf2fe_ready_o`=1, `count_o`=0.
- **Reset over flush:** reset mid-stream behaves as flush and takes priority over it.
- **Latency:** 1 cycle from push_fire to the earliest presentation. Presentation is combinational from registered state.
- **Ready path:** `ibuf2fe_ready_o` is purely a function of registered count. There is no combinational path from `fe2ibuf_valid_i` or `dec2ibuf_ready_i`.
- **Data stability:** while `ibuf2dec_valid_o`=1 and `dec2ibuf_ready_i`=0, presented data and mask hold stable unless a push raises n_pres. A push can only append slots; existing slots never change.
- **Wrap-around:** a push or pop that crosses entry DEPTH−1 continues at entry 0 with no bubble.

## Test plan
All scenarios use FW=DW=4, DEPTH=16.
- **Reset:** hold `rst_ni`=0 for 2 cycles → valid=0, ready=1, count=0, mask=0000.
- **Compaction:** push mask 1010 with PCs 0x100/0x104/0x108/0x10C and `dec2ibuf_ready_i`=0 → next cycle mask=0011, pcs_o[0]=0x104, pcs_o[1]=0x10C, count=2.
- **Full/backpressure:**
  - Push four full groups with decoder stalled → count=16, ready=0 (ready already 0 at count=13).
  - Then pop once → count=12, ready=1 on the next cycle.
- **Simultaneous push/pop and wrap:**
  - Stream 0x13-based instructions with PCs incrementing by 4, decoder always ready, for 10 cycles.
  - Required: head/tail wrap past entry 15, the PC order on output is strictly +4, and count stays at 4 in steady state.
- **Partial present:** count=3 with decoder ready → mask=0111, count becomes 0, and valid drops the next cycle.
- **Flush priority:** count=8, then assert `flush_i` together with a valid push and ready pop → next cycle count=0, valid=0. Instructions pushed afterwards appear at slot 0.
